// File: rtl/mmio_uart_if.sv
// Data-side memory bus as seen by a memory-mapped peripheral:
// byte address, store data/size from the core, registered read data and hit back.
interface mmio_uart_if;
    logic [13:0] d_addr;
    logic [31:0] dw_data;
    logic [1:0]  dw_size;
    logic [31:0] rd_data;
    logic        hit;

    modport master (output d_addr, dw_data, dw_size, input rd_data, hit);
    modport slave  (input d_addr, dw_data, dw_size, output rd_data, hit);
endinterface

// File: rtl/mmio_uart.sv
// Memory-mapped 8N1 UART transmitter: TXDATA stores feed a small FIFO that is
// serialised on tx; STATUS loads return FIFO/serialiser state with RAM-like latency.
module mmio_uart #(
    parameter logic [13:0] BASE_ADDR  = 14'h3F00,
    parameter int          CLK_DIV    = 16,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       resetn,
    mmio_uart_if.slave bus,
    output logic       tx,
    output logic       irq_empty
);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int BAUD_W = $clog2(CLK_DIV);
    localparam logic [11:0]       TX_WORD  = BASE_ADDR[13:2];
    localparam logic [11:0]       ST_WORD  = BASE_ADDR[13:2] + 12'd1;
    localparam logic [3:0]        DEPTH_C  = 4'(FIFO_DEPTH);
    localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state_reg, state_next;
    logic [BAUD_W-1:0] baud_reg, baud_next;
    logic [2:0]        bit_reg, bit_next;
    logic [7:0]        shift_reg, shift_next;
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [3:0]        count_reg;
    logic              overrun_reg;
    logic              tx_reg, tx_next;
    logic              irq_reg, irq_next;
    logic [31:0]       rd_data_reg;
    logic              hit_reg;

    logic [7:0] fifo_mem [FIFO_DEPTH];

    logic        sel_tx, sel_st, wr_tx, wr_st;
    logic        fifo_full, fifo_empty, pop, push, baud_done;
    logic [31:0] status_word;
    logic        unused_bits;

    assign sel_tx     = (bus.d_addr[13:2] == TX_WORD);
    assign sel_st     = (bus.d_addr[13:2] == ST_WORD);
    assign wr_tx      = (bus.dw_size != 2'b00) && sel_tx;
    assign wr_st      = (bus.dw_size != 2'b00) && sel_st;
    assign fifo_full  = (count_reg == DEPTH_C);
    assign fifo_empty = (count_reg == 4'd0);
    assign pop        = (state_reg == IDLE) && !fifo_empty;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign push       = wr_tx && (!fifo_full || pop);
    assign baud_done  = (baud_reg == '0);
    assign unused_bits = &{1'b0, bus.dw_data[31:8], bus.d_addr[1:0]};

    assign status_word = {20'h0, count_reg, 4'h0, overrun_reg,
                          (state_reg != IDLE), fifo_empty, fifo_full};

    always_ff @(posedge clk) begin
        if (push && !resetn)
            fifo_mem[wr_ptr_reg] <= bus.dw_data[7:0];
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_reg   <= IDLE;
            baud_reg    <= '0;
            bit_reg     <= 3'd0;
            shift_reg   <= 8'h00;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= 4'd0;
            overrun_reg <= 1'b0;
            tx_reg      <= 1'b1;
            irq_reg     <= 1'b1;
            rd_data_reg <= 32'h0;
            hit_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            baud_reg  <= baud_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            tx_reg    <= tx_next;
            irq_reg   <= irq_next;
            if (push)
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 4'd1;
                2'b01:   count_reg <= count_reg - 4'd1;
                default: count_reg <= count_reg;
            endcase
            if (wr_st)
                overrun_reg <= 1'b0;
            else if (wr_tx && !push)
                overrun_reg <= 1'b1;
            hit_reg     <= sel_tx | sel_st;
            rd_data_reg <= sel_st ? status_word : 32'h0;
        end
    end

    always_comb begin
        state_next = state_reg;
        baud_next  = baud_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        case (state_reg)
            IDLE: begin
                if (pop) begin
                    shift_next = fifo_mem[rd_ptr_reg];
                    baud_next  = BAUD_MAX;
                    bit_next   = 3'd0;
                    state_next = START;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_next  = BAUD_MAX;
                    bit_next   = 3'd0;
                    state_next = DATA;
                end else begin
                    baud_next = baud_reg - BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_next  = BAUD_MAX;
                    shift_next = {1'b0, shift_reg[7:1]};
                    bit_next   = bit_reg + 3'd1;
                    if (bit_reg == 3'd7)
                        state_next = STOP;
                end else begin
                    baud_next = baud_reg - BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_done)
                    state_next = IDLE;
                else
                    baud_next = baud_reg - BAUD_W'(1);
            end
            default: state_next = IDLE;
        endcase
    end

    // tx and irq_empty are registered copies of the current state's line level.
    always_comb begin
        tx_next  = 1'b1;
        irq_next = fifo_empty && (state_reg == IDLE);
        case (state_reg)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_reg[0];
            default: tx_next = 1'b1;
        endcase
    end

    assign bus.rd_data = rd_data_reg;
    assign bus.hit     = hit_reg;
    assign tx          = tx_reg;
    assign irq_empty   = irq_reg;
endmodule

// File: doc/mmio_uart.md
Name: mmio_uart

Overview:
- Memory-mapped UART transmitter that sits directly downstream of the core's memory-access stage, in parallel with the data RAM.
- Consumes the same data-side bus the core drives into RAM: byte address, write data and write size.
- Stores to its TXDATA word go into a TX FIFO, and the FIFO is serialised 8N1 on a single output pin.
- Loads from its STATUS word return FIFO and serialiser state with the same one-cycle read latency as RAM.

Parameters:
- BASE_ADDR, 14'h3F00, byte address of the register window. Must be 8-byte aligned. TXDATA is at BASE_ADDR+0 and STATUS is at BASE_ADDR+4.
- CLK_DIV, 16, clock cycles per UART bit. Must be ≥2.
- FIFO_DEPTH, 8, TX FIFO entries. Must be a power of 2, ≤15.

Ports:
- clk  in  1  clock; all state updates on its rising edge
- resetn  in  1  reset, asynchronous, active-high (asserted = 1)
- d_addr  in  14  data-side byte address from the core
- dw_data  in  32  store data; only [7:0] is used
- dw_size  in  2  store size: 00 none, 01 byte, 10 half, 11 word; any non-zero value is a write
- rd_data  out  32  registered read data for the address presented on the previous cycle
- hit  out  1  registered flag: the previous-cycle d_addr fell inside the 8-byte window
- tx  out  1  serial line, idle high
- irq_empty  out  1  high while the FIFO is empty and the serialiser is idle

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - tx=1, rd_data=0, hit=0, irq_empty=1.
  - FIFO read/write pointers and count = 0, state=IDLE, bit counter and baud counter = 0, overrun=0.
- Address decode: sel_tx = (d_addr[13:2]==BASE_ADDR[13:2]); sel_st = (d_addr[13:2]==BASE_ADDR[13:2]+1). d_addr[1:0] is ignored.
- Write to TXDATA (dw_size!=0 and sel_tx):
  - Push dw_data[7:0] if count<FIFO_DEPTH, or if a pop happens in the same cycle.
  - Otherwise drop the byte and set the sticky overrun flag.
- Write to STATUS (dw_size!=0 and sel_st): clears overrun. No other effect.
- Read path, one-cycle latency:
  - hit <= sel_tx|sel_st.
  - rd_data <= sel_st ? STATUS : 0. TXDATA reads as 0.
  - Reads have no side effects.
- STATUS layout:
  - bit0 full (count==FIFO_DEPTH)
  - bit1 empty (count==0)
  - bit2 busy (state!=IDLE)
  - bit3 overrun
  - bits[11:8] count
  - all other bits 0
- Serialiser FSM (IDLE, START, DATA, STOP):
  - IDLE: tx=1. If count>0, pop the head byte into a shift register, load baud counter with CLK_DIV-1, go to START on the next edge.
  - START: tx=0 for CLK_DIV cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for CLK_DIV cycles per bit, LSB first. Shift right after each bit. After bit 7, go to STOP.
  - STOP: tx=1 for CLK_DIV cycles, then go to IDLE.
  - The pop decision is evaluated again on the first IDLE cycle, so back-to-back frames have exactly 1 idle-high cycle between the stop bit and the next start bit.
- Timing:
  - A frame is 10*CLK_DIV cycles long.
  - tx falls 2 cycles after the write edge into an empty FIFO with an idle serialiser: push on edge 0, pop on edge 1, START drives tx from edge 2.
  - tx is a registered output.
- Count arithmetic:
  - Push only: +1. Pop only: −1. Simultaneous push and pop: unchanged.
  - Pointers are log2(FIFO_DEPTH) bits wide and wrap naturally.
- irq_empty is registered: the value of (count==0 && state==IDLE), one cycle late.
- Bytes written during STOP or DATA are queued and never corrupt the byte in flight.

Test Plan:
- Reset then idle (CLK_DIV=4):
  - Stimulus: assert resetn mid-frame, then release.
  - Required: tx=1 immediately; STATUS read returns 0x0000_0002; irq_empty=1.
- Single byte:
  - Stimulus: store word 0x0000_00A5 to 0x3F00.
  - Required: tx falls 2 cycles later; bit sequence 0,1,0,1,0,0,1,0,1,1, each 4 cycles; 40-cycle frame; irq_empty rises after STOP ends.
- Back-to-back:
  - Stimulus: 3 byte stores 0x11, 0x22, 0x33 on consecutive cycles.
  - Required: three frames in order, each separated by exactly 1 idle-high cycle; STATUS count reads 2 right after the first pop.
- Overflow (FIFO_DEPTH=8):
  - Stimulus: 10 stores in consecutive cycles.
  - Required: 9 bytes accepted (1 popped, 8 queued); 10th dropped; STATUS=0x0000_080D (count 8, overrun, busy, full). A store to 0x3F04 then clears bit3.
- Full plus simultaneous pop:
  - Stimulus: with the FIFO full, store in the same cycle the FSM pops.
  - Required: byte accepted, count stays 8, no overrun.
- Decode:
  - Stimulus: read 0x3F04 → next cycle hit=1, rd_data=STATUS. Read 0x3F08 → hit=0, rd_data=0. Word store to 0x3EFC → no FIFO change.
  - Required: as stated for each access.
